sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
- REQ-001 The block SHALL have parameter LATENCY, default 1, meaning the SRAM read latency in cycles from the enable cycle to the cycle sram_rdata is valid; legal range 1..7.
- REQ-002 clk  input  1  single clock; all state updates on its rising edge.
- REQ-003 rst  input  1  reset, asynchronous assertion, active-low.
- REQ-004 inst_req  input  1  fetch-side read request; held until granted.
- REQ-005 inst_addr  input  32  fetch address.
- REQ-006 inst_gnt  output  1  fetch request accepted this cycle.
- REQ-007 inst_rvalid  output  1  one-cycle pulse; inst_rdata valid.
- REQ-008 inst_rdata  output  32  registered fetch data.
- REQ-009 data_req  input  1  load/store request; held until granted.
- REQ-010 data_wen  input  4  byte write enables; 0 means load.
- REQ-011 data_addr, data_wdata  input  32 each  load/store address and store data.
- REQ-012 data_gnt  output  1  data request accepted this cycle.
- REQ-013 data_rvalid  output  1  one-cycle pulse; data_rdata valid (loads only).
- REQ-014 data_rdata  output  32  registered raw load word (byte/half extraction stays downstream).
- REQ-015 sram_en, sram_wen[3:0], sram_addr[31:0], sram_wdata[31:0]  output  shared single-port SRAM command.
- REQ-016 sram_rdata  input  32  SRAM read data.
- REQ-017 stallreq  output  1  pipeline stall request to the stall controller.

Function
- REQ-018 States SHALL be IDLE and WAIT; a 3-bit counter SHALL track cycles elapsed in WAIT.
- REQ-019 A grant SHALL be issued only when state is IDLE, or in WAIT in the cycle the counter reaches LATENCY (back-to-back issue).
- REQ-020 On grant, sram_en SHALL be 1 and sram_wen/addr/wdata SHALL be driven combinationally from the granted requester in the same cycle; at most one gnt per cycle.
- REQ-021 Priority SHALL be data over inst, except when data was granted in each of the two preceding grants while inst_req was high, then inst SHALL win.
- REQ-022 A granted read SHALL enter WAIT with counter cleared and record its owner; a granted store (data_wen!=0) SHALL NOT enter WAIT and SHALL NOT produce rvalid.
- REQ-023 In the cycle the counter equals LATENCY, sram_rdata SHALL be captured into the owner's rdata register, and that owner's rvalid SHALL be 1 for exactly the following cycle.
- REQ-024 If no new read is granted in the capture cycle, state SHALL return to IDLE.
- REQ-025 sram_en SHALL be 0 and sram_wen SHALL be 0 in every cycle without a grant.
- REQ-026 stallreq SHALL equal (inst_req & ~inst_gnt) | (data_req & ~data_gnt) | (state==WAIT).
- REQ-027 Simultaneous inst_req and data_req in IDLE with a clean history SHALL grant data only; inst SHALL be granted no later than the next free issue slot.

Reset
- REQ-028 While rst is low: state IDLE, counter 0, priority history cleared, inst_rvalid, data_rvalid, inst_rdata, data_rdata all 0, and all gnt and sram_* outputs 0.
- REQ-029 Reset asserted during WAIT SHALL abandon the outstanding read; no rvalid SHALL follow reset release.

Configuration
- REQ-030 With SRAM_ARB_PERF_EN defined, outputs inst_gnt_cnt[31:0] and data_gnt_cnt[31:0] SHALL exist, reset to 0, increment by one per respective grant, and wrap from 0xFFFFFFFF to 0.
- REQ-031 Without SRAM_ARB_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
- REQ-032 LATENCY=1, data_req load addr 0x100, sram_rdata=0xDEADBEEF one cycle later -> data_gnt at T, data_rvalid at T+2 with data_rdata=0xDEADBEEF.
- REQ-033 inst_req and data_req both held high for 6 cycles, all loads, LATENCY=1 -> grant order data,data,inst,data,data,inst.
- REQ-034 data store wen=4'b0011 addr 0x20 wdata 0x1234 -> sram_wen=0011 in grant cycle, no data_rvalid, next request grantable next cycle.
- REQ-035 LATENCY=3, inst read granted at T -> stallreq high T..T+3, inst_rvalid only at T+4.
- REQ-036 rst driven low at T+1 after a read grant at T -> all outputs 0 immediately; no rvalid after release.
- REQ-037 SRAM_ARB_PERF_EN defined, data_gnt_cnt preloaded-by-traffic to 0xFFFFFFFF, one data grant -> data_gnt_cnt=0.

Source files
------------

// File: rtl/sram_arb_if.sv
// Bundle of fetch-side, load/store-side and shared SRAM command signals for sram_arb.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters plus the SRAM.
interface sram_arb_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic        stallreq;

  modport slave (
    input  inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata, stallreq
  );

  modport master (
    output inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    input  inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata, stallreq
  );
endinterface

// File: rtl/sram_arb.sv
// Arbiter sharing one single-port SRAM between instruction fetch and load/store.
// Data normally has priority. Fetch wins after two consecutive data grants that
// were made while fetch was waiting. Reads hold the port for LATENCY cycles. A new
// grant can issue in the capture cycle, so reads can run back-to-back.
// Optional grant counters are enabled by defining SRAM_ARB_PERF_EN.
module sram_arb #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  sram_arb_if.slave   bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0] inst_gnt_cnt,
  output logic [31:0] data_gnt_cnt
`endif
);

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("sram_arb: LATENCY must be in 1..7");
  end

  typedef enum logic {StIdle, StWait} state_e;

  // The counter holds LATENCY-1 in the cycle the read data is valid.
  localparam logic [2:0] LastCnt = 3'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  streak_q, streak_d;  // data grants in a row while inst_req waited
  logic        owner_q, owner_d;    // 1: outstanding read belongs to data side
  logic        inst_rvalid_q, data_rvalid_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic capture, issue_ok, inst_wins, inst_gnt, data_gnt, data_read, new_read;

  // Grant decision and SRAM command; grants are suppressed while in reset.
  always_comb begin
    capture   = (state_q == StWait) && (cnt_q == LastCnt);
    issue_ok  = rst && ((state_q == StIdle) || capture);
    inst_wins = bus.inst_req && (streak_q == 2'd2);
    data_gnt  = issue_ok && bus.data_req && !inst_wins;
    inst_gnt  = issue_ok && bus.inst_req && !data_gnt;
    data_read = data_gnt && (bus.data_wen == 4'b0000);
    new_read  = inst_gnt || data_read;

    bus.inst_gnt   = inst_gnt;
    bus.data_gnt   = data_gnt;
    bus.sram_en    = inst_gnt || data_gnt;
    bus.sram_wen   = data_gnt ? bus.data_wen : 4'b0000;
    bus.sram_wdata = data_gnt ? bus.data_wdata : 32'h0;
    bus.sram_addr  = data_gnt ? bus.data_addr : (inst_gnt ? bus.inst_addr : 32'h0);
    bus.stallreq   = rst && ((bus.inst_req && !inst_gnt) || (bus.data_req && !data_gnt) ||
                             (state_q == StWait));
  end

  // Next state, wait counter, read owner and priority history.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    if (state_q == StWait) begin
      cnt_d = cnt_q + 3'd1;
      if (capture) begin
        state_d = StIdle;
      end
    end
    if (new_read) begin
      state_d = StWait;
      cnt_d   = 3'd0;
      owner_d = data_read;
    end
    if (data_gnt) begin
      if (bus.inst_req) begin
        streak_d = (streak_q == 2'd2) ? 2'd2 : streak_q + 2'd1;
      end else begin
        streak_d = 2'd0;
      end
    end else if (inst_gnt) begin
      streak_d = 2'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      owner_q  <= 1'b0;
      streak_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Capture read data for the owner and pulse its rvalid in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_rdata_q  <= 32'h0;
      data_rdata_q  <= 32'h0;
    end else begin
      inst_rvalid_q <= capture && !owner_q;
      data_rvalid_q <= capture && owner_q;
      if (capture && !owner_q) begin
        inst_rdata_q <= bus.sram_rdata;
      end
      if (capture && owner_q) begin
        data_rdata_q <= bus.sram_rdata;
      end
    end
  end

  assign bus.inst_rvalid = inst_rvalid_q;
  assign bus.data_rvalid = data_rvalid_q;
  assign bus.inst_rdata  = inst_rdata_q;
  assign bus.data_rdata  = data_rdata_q;

`ifdef SRAM_ARB_PERF_EN
  // Free-running grant counters; they wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_gnt_cnt <= 32'h0;
      data_gnt_cnt <= 32'h0;
    end else begin
      inst_gnt_cnt <= inst_gnt_cnt + 32'(inst_gnt);
      data_gnt_cnt <= data_gnt_cnt + 32'(data_gnt);
    end
  end
`endif

endmodule

// File: tb/tb_sram_arb.sv
// Self-checking bench for sram_arb: two instances (LATENCY 1 and 3), directed
// scenarios followed by random traffic, all checked against a cycle-schedule model.
module tb_sram_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        inst_req   [2];
  logic [31:0] inst_addr  [2];
  logic        data_req   [2];
  logic [3:0]  data_wen   [2];
  logic [31:0] data_addr  [2];
  logic [31:0] data_wdata [2];
  logic [31:0] sram_rdata [2];

  wire        inst_gnt    [2];
  wire        inst_rvalid [2];
  wire [31:0] inst_rdata  [2];
  wire        data_gnt    [2];
  wire        data_rvalid [2];
  wire [31:0] data_rdata  [2];
  wire        sram_en     [2];
  wire [3:0]  sram_wen    [2];
  wire [31:0] sram_addr   [2];
  wire [31:0] sram_wdata  [2];
  wire        stallreq    [2];
`ifdef SRAM_ARB_PERF_EN
  wire [31:0] icnt [2];
  wire [31:0] dcnt [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arb_if bus ();
    assign bus.inst_req   = inst_req[g];
    assign bus.inst_addr  = inst_addr[g];
    assign bus.data_req   = data_req[g];
    assign bus.data_wen   = data_wen[g];
    assign bus.data_addr  = data_addr[g];
    assign bus.data_wdata = data_wdata[g];
    assign bus.sram_rdata = sram_rdata[g];
    assign inst_gnt[g]    = bus.inst_gnt;
    assign inst_rvalid[g] = bus.inst_rvalid;
    assign inst_rdata[g]  = bus.inst_rdata;
    assign data_gnt[g]    = bus.data_gnt;
    assign data_rvalid[g] = bus.data_rvalid;
    assign data_rdata[g]  = bus.data_rdata;
    assign sram_en[g]     = bus.sram_en;
    assign sram_wen[g]    = bus.sram_wen;
    assign sram_addr[g]   = bus.sram_addr;
    assign sram_wdata[g]  = bus.sram_wdata;
    assign stallreq[g]    = bus.stallreq;
    sram_arb #(.LATENCY((g == 0) ? 1 : 3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SRAM_ARB_PERF_EN
      ,
      .inst_gnt_cnt (icnt[g]),
      .data_gnt_cnt (dcnt[g])
`endif
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: per-instance schedule of when the port is free and when
  // the outstanding read returns.
  int          next_issue [2];
  bit          out_v      [2];
  bit          owner_data [2];
  int          cap_c      [2];
  int          streak     [2];
  logic        e_irv      [2];
  logic        e_drv      [2];
  logic [31:0] e_ird      [2];
  logic [31:0] e_drd      [2];
  bit          i_pend     [2];
  bit          d_pend     [2];
  logic [31:0] e_icnt     [2];
  logic [31:0] e_dcnt     [2];

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d got=0x%08h exp=0x%08h", tag, d, got, exp);
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      int lat = (d == 0) ? 1 : 3;
      bit gi = 1'b0;
      bit gd = 1'b0;
      bit cap;
      bit rd;
      if (!rst) begin
        chk("rst_inst_gnt", d, 32'(inst_gnt[d]), 32'd0);
        chk("rst_data_gnt", d, 32'(data_gnt[d]), 32'd0);
        chk("rst_sram_en", d, 32'(sram_en[d]), 32'd0);
        chk("rst_sram_wen", d, 32'(sram_wen[d]), 32'd0);
        chk("rst_stallreq", d, 32'(stallreq[d]), 32'd0);
        chk("rst_inst_rvalid", d, 32'(inst_rvalid[d]), 32'd0);
        chk("rst_data_rvalid", d, 32'(data_rvalid[d]), 32'd0);
        chk("rst_inst_rdata", d, inst_rdata[d], 32'd0);
        chk("rst_data_rdata", d, data_rdata[d], 32'd0);
        next_issue[d] = 0;
        out_v[d] = 1'b0;
        owner_data[d] = 1'b0;
        streak[d] = 0;
        e_irv[d] = 1'b0;
        e_drv[d] = 1'b0;
        e_ird[d] = 32'h0;
        e_drd[d] = 32'h0;
        e_icnt[d] = 32'h0;
        e_dcnt[d] = 32'h0;
        i_pend[d] = inst_req[d];
        d_pend[d] = data_req[d];
      end else begin
        if (cyc >= next_issue[d]) begin
          if (inst_req[d] && streak[d] == 2) gi = 1'b1;
          else if (data_req[d]) gd = 1'b1;
          else if (inst_req[d]) gi = 1'b1;
        end
        chk("inst_gnt", d, 32'(inst_gnt[d]), 32'(gi));
        chk("data_gnt", d, 32'(data_gnt[d]), 32'(gd));
        chk("sram_en", d, 32'(sram_en[d]), 32'(gi | gd));
        chk("sram_wen", d, 32'(sram_wen[d]), gd ? 32'(data_wen[d]) : 32'd0);
        if (gd) begin
          chk("sram_addr_d", d, sram_addr[d], data_addr[d]);
          chk("sram_wdata", d, sram_wdata[d], data_wdata[d]);
        end
        if (gi) chk("sram_addr_i", d, sram_addr[d], inst_addr[d]);
        chk("stallreq", d, 32'(stallreq[d]),
            32'((inst_req[d] && !gi) || (data_req[d] && !gd) || out_v[d]));
        chk("inst_rvalid", d, 32'(inst_rvalid[d]), 32'(e_irv[d]));
        chk("data_rvalid", d, 32'(data_rvalid[d]), 32'(e_drv[d]));
        chk("inst_rdata", d, inst_rdata[d], e_ird[d]);
        chk("data_rdata", d, data_rdata[d], e_drd[d]);
`ifdef SRAM_ARB_PERF_EN
        chk("inst_gnt_cnt", d, icnt[d], e_icnt[d]);
        chk("data_gnt_cnt", d, dcnt[d], e_dcnt[d]);
        e_icnt[d] = e_icnt[d] + 32'(gi);
        e_dcnt[d] = e_dcnt[d] + 32'(gd);
`endif
        cap = out_v[d] && (cyc == cap_c[d]);
        e_irv[d] = cap && !owner_data[d];
        e_drv[d] = cap && owner_data[d];
        if (cap && owner_data[d]) e_drd[d] = sram_rdata[d];
        if (cap && !owner_data[d]) e_ird[d] = sram_rdata[d];
        if (cap) out_v[d] = 1'b0;
        rd = gi || (gd && data_wen[d] == 4'b0000);
        if (rd) begin
          out_v[d] = 1'b1;
          owner_data[d] = gd;
          cap_c[d] = cyc + lat;
          next_issue[d] = cyc + lat;
        end else if (gd) begin
          next_issue[d] = cyc + 1;
        end
        if (gd) streak[d] = inst_req[d] ? ((streak[d] == 2) ? 2 : streak[d] + 1) : 0;
        else if (gi) streak[d] = 0;
        i_pend[d] = inst_req[d] && !gi;
        d_pend[d] = data_req[d] && !gd;
      end
    end
  endtask

  // One clock cycle: inputs were set at the falling edge, check, move to next edge.
  task automatic step();
    #1;
    check_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input int d, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] w, input logic [31:0] da, input logic [31:0] wd);
    inst_req[d]   = ir;
    inst_addr[d]  = ia;
    data_req[d]   = dr;
    data_wen[d]   = w;
    data_addr[d]  = da;
    data_wdata[d] = wd;
  endtask

  task automatic drive_all(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic [3:0] w, input logic [31:0] da, input logic [31:0] wd);
    for (int d = 0; d < 2; d++) drive(d, ir, ia, dr, w, da, wd);
  endtask

  logic [1:0] order [6];

  initial begin
    rst = 1'b0;
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) sram_rdata[d] = 32'h0;
    @(negedge clk);

    // Reset held, requests present: nothing may be granted.
    drive_all(1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
    step();
    step();
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    step();

    // Single load of 0x100, data returns one cycle later.
    drive_all(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    #1;
    chk("load_gnt", 0, 32'(data_gnt[0]), 32'd1);
    chk("load_addr", 0, sram_addr[0], 32'h100);
    step();
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int d = 0; d < 2; d++) sram_rdata[d] = 32'hDEADBEEF;
    step();
    #1;
    chk("load_rvalid", 0, 32'(data_rvalid[0]), 32'd1);
    chk("load_rdata", 0, data_rdata[0], 32'hDEADBEEF);
    step();
    for (int i = 0; i < 3; i++) step();

    // Both sides hold load requests: data, data, inst, repeating.
    order = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    drive_all(1'b1, 32'h400, 1'b1, 4'h0, 32'h800, 32'h0);
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) sram_rdata[d] = $urandom;
      #1;
      chk("grant_order", 0, 32'({inst_gnt[0], data_gnt[0]}), 32'(order[i]));
      step();
    end
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step();

    // Stores do not occupy the port beyond their grant cycle.
    drive_all(1'b0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'h1234);
    #1;
    chk("store_gnt", 0, 32'(data_gnt[0]), 32'd1);
    chk("store_wen", 0, 32'(sram_wen[0]), 32'h3);
    chk("store_wdata", 0, sram_wdata[0], 32'h1234);
    step();
    drive_all(1'b0, 32'h0, 1'b1, 4'b1100, 32'h24, 32'h5678);
    #1;
    chk("store_b2b_gnt", 0, 32'(data_gnt[0]), 32'd1);
    chk("store_no_rvalid", 0, 32'(data_rvalid[0]), 32'd0);
    step();
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("store_no_rvalid2", 0, 32'(data_rvalid[0]), 32'd0);
    step();

    // LATENCY=3 fetch: stall through the wait, rvalid four cycles after grant.
    drive_all(1'b1, 32'h40, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("l3_gnt", 1, 32'(inst_gnt[1]), 32'd1);
    step();
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      sram_rdata[1] = $urandom;
      #1;
      chk("l3_stall", 1, 32'(stallreq[1]), 32'd1);
      chk("l3_no_rvalid", 1, 32'(inst_rvalid[1]), 32'd0);
      step();
    end
    #1;
    chk("l3_rvalid", 1, 32'(inst_rvalid[1]), 32'd1);
    chk("l3_stall_end", 1, 32'(stallreq[1]), 32'd0);
    step();

    // Reset in the middle of a read abandons it.
    drive_all(1'b1, 32'h80, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    drive_all(1'b1, 32'h84, 1'b1, 4'h0, 32'h88, 32'h0);
    step();
    step();
    rst = 1'b1;
    drive_all(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("post_rst_irv", 0, 32'(inst_rvalid[0]), 32'd0);
      chk("post_rst_irv", 1, 32'(inst_rvalid[1]), 32'd0);
      step();
    end

    // Random traffic; requests stay stable until granted.
    for (int i = 0; i < 800; i++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (!i_pend[d]) begin
          inst_req[d]  = ($urandom_range(0, 99) < 60);
          inst_addr[d] = $urandom;
        end
        if (!d_pend[d]) begin
          data_req[d]   = ($urandom_range(0, 99) < 60);
          data_wen[d]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
          data_addr[d]  = $urandom;
          data_wdata[d] = $urandom;
        end
        sram_rdata[d] = $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
